pid_steer_ctrl_p: RTL and testbench

Parametrised second-generation line-follower steering PID: the same P/I/D steering law, generalised in widths, with runtime-programmable gains and a registered two-stage datapath with a valid handshake.
- Adds a forward-speed FSM with controlled braking instead of an instant stop.
- Adds signed anti-windup, and saturation of both motor commands instead of wrap-around.
- Sits between the line-error calculator and the motor PWM drivers.

---
 rtl/pid_steer_ctrl_p.sv | 193 +++++++++++++++++++
 tb/tb_pid_steer_ctrl_p.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pid_steer_ctrl_p.sv
// Line-follower steering PID with saturating P/I/D terms, a two-stage registered
// datapath with a valid pulse, and a forward-speed ramp/cruise/brake FSM.
module pid_steer_ctrl_p #(
  parameter int ERR_W      = 16,
  parameter int ESAT_W     = 11,
  parameter int DSAT_W     = 8,
  parameter int INT_W      = 16,
  parameter int COEF_W     = 7,
  parameter int SPD_W      = 12,
  parameter int I_SHIFT    = 6,
  parameter int STEP       = 4,
  parameter int BRAKE_STEP = 16,
  parameter int MAX_SPD    = 'h300,
  parameter int MOVE_THR   = 'h080
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic                    line_present,
  input  logic                    err_vld,
  input  logic signed [ERR_W-1:0] error,
  input  logic [COEF_W-1:0]       kp,
  input  logic [COEF_W-1:0]       kd,
  output logic [SPD_W-1:0]        lft_speed,
  output logic [SPD_W-1:0]        rght_speed,
  output logic                    moving,
  output logic                    out_vld,
  output logic [1:0]              state
);

  localparam int P_W   = ESAT_W + COEF_W + 1;
  localparam int DT_W  = DSAT_W + COEF_W + 1;
  localparam int DR_W  = ESAT_W + 1;
  localparam int W0    = (P_W > DT_W) ? P_W : DT_W;
  localparam int SUM_W = ((W0 > INT_W) ? W0 : INT_W) + 2;
  localparam int OUT_W = ((SUM_W > SPD_W) ? SUM_W : SPD_W) + 2;
  localparam int F_W   = SPD_W - 1;

  localparam logic signed [ERR_W-1:0]  ERR_HI  = ERR_W'((2 ** (ESAT_W - 1)) - 1);
  localparam logic signed [ERR_W-1:0]  ERR_LO  = ERR_W'(-(2 ** (ESAT_W - 1)));
  localparam logic signed [ESAT_W-1:0] ESAT_HI = {1'b0, {(ESAT_W-1){1'b1}}};
  localparam logic signed [ESAT_W-1:0] ESAT_LO = {1'b1, {(ESAT_W-1){1'b0}}};
  localparam logic signed [DR_W-1:0]   DRAW_HI = DR_W'((2 ** (DSAT_W - 1)) - 1);
  localparam logic signed [DR_W-1:0]   DRAW_LO = DR_W'(-(2 ** (DSAT_W - 1)));
  localparam logic signed [DSAT_W-1:0] DSAT_HI = {1'b0, {(DSAT_W-1){1'b1}}};
  localparam logic signed [DSAT_W-1:0] DSAT_LO = {1'b1, {(DSAT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0]  SPD_MAX = OUT_W'((2 ** SPD_W) - 1);
  localparam logic [F_W-1:0] F_MAX  = F_W'(MAX_SPD);
  localparam logic [F_W-1:0] F_STEP = F_W'(STEP);
  localparam logic [F_W-1:0] F_BRK  = F_W'(BRAKE_STEP);
  localparam logic [F_W-1:0] F_THR  = F_W'(MOVE_THR);

  typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, CRUISE = 2'd2, BRAKE = 2'd3} state_e;

  state_e                   state_q, state_d;
  logic [F_W-1:0]           f_q, f_d;
  logic [F_W:0]             f_inc;
  logic signed [ESAT_W-1:0] e1_q, e1_d, e2_q, e2_d, err_sat;
  logic signed [DR_W-1:0]   d_raw;
  logic signed [DSAT_W-1:0] d_sat;
  logic signed [INT_W-1:0]  integ_q, integ_d, int_ext, int_sum;
  logic                     int_ovf, int_clr;
  logic                     line_prev_q, line_prev_d;
  logic signed [P_W-1:0]    p_q, p_d;
  logic signed [INT_W-1:0]  i_q, i_d;
  logic signed [DT_W-1:0]   dt_q, dt_d;
  logic                     v1_q, v1_d, out_vld_q, out_vld_d;
  logic signed [SUM_W-1:0]  s_sum, s_val;
  logic signed [OUT_W-1:0]  f_ext, lft_wide, rght_wide;
  logic [SPD_W-1:0]         lft_q, lft_d, rght_q, rght_d;

  function automatic logic [SPD_W-1:0] clamp_spd(input logic signed [OUT_W-1:0] v);
    if (v[OUT_W-1])   return '0;
    if (v > SPD_MAX)  return '1;
    return v[SPD_W-1:0];
  endfunction

  assign moving = (f_q > F_THR);

  // Forward-speed FSM; go=1 in BRAKE is only seen once IDLE is reached.
  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    f_inc   = {1'b0, f_q} + {1'b0, F_STEP};
    unique case (state_q)
      IDLE: begin
        f_d = '0;
        if (go) state_d = RAMP;
      end
      RAMP: begin
        if (!go) begin
          state_d = BRAKE;
        end else if (err_vld) begin
          f_d = (f_inc >= {1'b0, F_MAX}) ? F_MAX : f_inc[F_W-1:0];
          if (f_d == F_MAX) state_d = CRUISE;
        end
      end
      CRUISE: if (!go) state_d = BRAKE;
      BRAKE: begin
        f_d = (f_q > F_BRK) ? (f_q - F_BRK) : '0;
        if (f_d == '0) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    if (error > ERR_HI)      err_sat = ESAT_HI;
    else if (error < ERR_LO) err_sat = ESAT_LO;
    else                     err_sat = error[ESAT_W-1:0];

    d_raw = DR_W'(err_sat) - DR_W'(e2_q);
    if (d_raw > DRAW_HI)      d_sat = DSAT_HI;
    else if (d_raw < DRAW_LO) d_sat = DSAT_LO;
    else                      d_sat = d_raw[DSAT_W-1:0];

    e1_d = err_vld ? err_sat : e1_q;
    e2_d = err_vld ? e1_q : e2_q;

    // Same-sign operands whose sum changes sign would wrap: hold instead.
    int_ext = INT_W'(err_sat);
    int_sum = integ_q + int_ext;
    int_ovf = (integ_q[INT_W-1] == int_ext[INT_W-1]) && (int_sum[INT_W-1] != integ_q[INT_W-1]);
    line_prev_d = line_present;
    int_clr = (line_present && !line_prev_q) || !moving || (state_q == IDLE) || (state_q == BRAKE);
    integ_d = integ_q;
    if (int_clr)                  integ_d = '0;
    else if (err_vld && !int_ovf) integ_d = int_sum;

    v1_d = err_vld;
    p_d  = p_q;
    i_d  = i_q;
    dt_d = dt_q;
    if (err_vld) begin
      p_d  = P_W'($signed({1'b0, kp})) * P_W'(err_sat);
      i_d  = integ_q >>> I_SHIFT;
      dt_d = DT_W'($signed({1'b0, kd})) * DT_W'(d_sat);
    end

    // Sum and speed arithmetic are wide enough that no gain setting can wrap before the clamp.
    s_sum     = SUM_W'(p_q) + SUM_W'(i_q) + SUM_W'(dt_q);
    s_val     = s_sum >>> 3;
    f_ext     = OUT_W'($signed({1'b0, f_q}));
    lft_wide  = f_ext + OUT_W'(s_val);
    rght_wide = f_ext - OUT_W'(s_val);
    out_vld_d = v1_q;
    lft_d     = lft_q;
    rght_d    = rght_q;
    if (v1_q) begin
      lft_d  = moving ? clamp_spd(lft_wide)  : {1'b0, f_q};
      rght_d = moving ? clamp_spd(rght_wide) : {1'b0, f_q};
    end
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      f_q         <= '0;
      e1_q        <= '0;
      e2_q        <= '0;
      integ_q     <= '0;
      line_prev_q <= 1'b0;
      p_q         <= '0;
      i_q         <= '0;
      dt_q        <= '0;
      v1_q        <= 1'b0;
      out_vld_q   <= 1'b0;
      lft_q       <= '0;
      rght_q      <= '0;
    end else begin
      state_q     <= state_d;
      f_q         <= f_d;
      e1_q        <= e1_d;
      e2_q        <= e2_d;
      integ_q     <= integ_d;
      line_prev_q <= line_prev_d;
      p_q         <= p_d;
      i_q         <= i_d;
      dt_q        <= dt_d;
      v1_q        <= v1_d;
      out_vld_q   <= out_vld_d;
      lft_q       <= lft_d;
      rght_q      <= rght_d;
    end
  end

  assign lft_speed  = lft_q;
  assign rght_speed = rght_q;
  assign out_vld    = out_vld_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pid_steer_ctrl_p.sv
// Scoreboard bench for pid_steer_ctrl_p: directed strobes push hand-computed
// speeds; an independent monitor pops and compares on every out_vld pulse.
module tb_pid_steer_ctrl_p;

  logic        clk = 1'b0;
  logic        rst, go, line_present, err_vld;
  logic [15:0] error;
  logic [6:0]  kp, kd;
  logic [11:0] lft_speed, rght_speed;
  logic        moving, out_vld;
  logic [1:0]  state;

  pid_steer_ctrl_p dut (
    .clk(clk), .rst(rst), .go(go), .line_present(line_present),
    .err_vld(err_vld), .error(error), .kp(kp), .kd(kd),
    .lft_speed(lft_speed), .rght_speed(rght_speed),
    .moving(moving), .out_vld(out_vld), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lft;
    int rght;
    int due;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   hold_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expect_out(input int l, input int r);
    exp_t x;
    x.lft  = l;
    x.rght = r;
    x.due  = cyc + 2;
    sb_q.push_back(x);
  endtask

  // Called on a negedge; returns on the following negedge with err_vld low.
  task automatic strobe(input logic [15:0] e, input int l, input int r);
    err_vld = 1'b1;
    error   = e;
    expect_out(l, r);
    @(negedge clk);
    err_vld = 1'b0;
  endtask

  task automatic clear_integrator();
    line_present = 1'b0;
    @(negedge clk);
    line_present = 1'b1;
    @(negedge clk);
  endtask

  // Error held at zero: each strobe's output is the forward speed after that strobe.
  task automatic ramp(input int n);
    for (int k = 1; k <= n; k++) begin
      int f;
      f = (4 * k > 768) ? 768 : 4 * k;
      strobe(16'h0000, f, f);
      if (k == 32)  check("ramp_not_moving_f080", int'(moving), 0);
      if (k == 33)  check("ramp_moving_f084", int'(moving), 1);
      if (k == 191) check("ramp_state_f2fc", int'(state), 1);
      if (k == 192) check("cruise_at_f300", int'(state), 2);
    end
  endtask

  initial begin
    exp_t x;
    int   last_l = 0;
    int   last_r = 0;
    bit   have_last = 1'b0;
    forever begin
      @(negedge clk);
      if (out_vld) begin
        check("sb_pending", int'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          x = sb_q.pop_front();
          check("out_latency", cyc, x.due);
          check("lft_speed", int'(lft_speed), x.lft);
          check("rght_speed", int'(rght_speed), x.rght);
        end
        last_l    = int'(lft_speed);
        last_r    = int'(rght_speed);
        have_last = 1'b1;
      end else if (hold_en && have_last) begin
        check("lft_hold", int'(lft_speed), last_l);
        check("rght_hold", int'(rght_speed), last_r);
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench still running after %0d cycles", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; go = 1'b0; line_present = 1'b0; err_vld = 1'b0;
    error = '0; kp = '0; kd = '0;
    repeat (2) @(negedge clk);
    check("rst_lft", int'(lft_speed), 0);
    check("rst_rght", int'(rght_speed), 0);
    check("rst_state", int'(state), 0);
    check("rst_moving", int'(moving), 0);
    check("rst_out_vld", int'(out_vld), 0);

    rst = 1'b0; line_present = 1'b1;
    @(negedge clk);
    check("idle_without_go", int'(state), 0);
    go = 1'b1;
    @(negedge clk);
    check("idle_to_ramp_first", int'(state), 1);
    ramp(200);
    check("cruise_holds", int'(state), 2);

    // Error saturation in CRUISE, F=0x300; integrator starts at 0.
    kp = 7'd6; kd = 7'd0;
    strobe(16'h7FFF, 1535, 1);     // P=6138, S=767
    strobe(16'h8000, 1, 1535);     // P=-6144, I=1023>>>6=15, S=-767

    // Anti-windup: integrator climbs 1023 per strobe and holds at 32736.
    clear_integrator();
    kp = 7'd0;
    for (int j = 1; j <= 40; j++) begin
      int s;
      s = (1023 * ((j - 1 > 32) ? 32 : j - 1)) / 512;
      strobe(16'h03FF, 768 + s, 768 - s);
    end
    clear_integrator();
    strobe(16'h0000, 768, 768);    // integrator cleared by line rising edge
    strobe(16'h0000, 768, 768);    // history now e1=e2=0

    // Clamping of both motor commands and of the derivative.
    kp = 7'd6; kd = 7'h38;
    strobe(16'h03FF, 2424, 0);     // P=6138, Dt=56*127=7112, S=1656
    kp = 7'd127; kd = 7'd0;
    strobe(16'h03FF, 4095, 0);     // P=129921, I=15, S=16242
    kp = 7'd0; kd = 7'h38;
    strobe(16'h8000, 0, 1661);     // D=-2047->-128, Dt=-7168, I=31, S=-893
    kd = 7'd0;

    // Braking: first edge enters BRAKE, then F drops 16 per clk.
    go = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (n == 1)  check("brake_entry", int'(state), 3);
      if (n == 10) go = 1'b1;
      if (n == 40) check("brake_moving_f090", int'(moving), 1);
      if (n == 41) check("brake_stopped_f080", int'(moving), 0);
      if (n == 43) begin
        err_vld = 1'b1;
        error   = 16'h03FF;
        expect_out(80, 80);        // not moving: both sides equal F
      end
      if (n == 44) err_vld = 1'b0;
      if (n == 48) check("brake_ignores_go", int'(state), 3);
      if (n == 49) check("brake_to_idle", int'(state), 0);
      if (n == 50) check("idle_to_ramp_again", int'(state), 1);
    end

    ramp(192);
    repeat (3) @(negedge clk);

    // Reset mid-CRUISE with a strobe offered: it must never produce out_vld.
    hold_en = 1'b0;
    rst = 1'b1; err_vld = 1'b1; error = 16'h03FF;
    @(negedge clk);
    err_vld = 1'b0;
    check("midrst_lft", int'(lft_speed), 0);
    check("midrst_rght", int'(rght_speed), 0);
    check("midrst_state", int'(state), 0);
    check("midrst_moving", int'(moving), 0);
    check("midrst_out_vld", int'(out_vld), 0);
    rst = 1'b0; go = 1'b0;
    @(negedge clk);
    check("post_rst_idle", int'(state), 0);
    repeat (4) @(negedge clk);
    check("sb_drained", int'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
